baud_tick_generator: RTL

- Parametrised successor to the fixed-divide UART baud clock.
- Produces a one-cycle oversample strobe from a runtime-loadable fractional divisor (integer plus fractional clock cycles per oversample tick). No hardware divider is used.
- Derives bit-boundary and mid-bit strobes from the oversample strobe.
- Supports resync to a receiver start edge. Shared by the UART TX and RX paths.

---
 rtl/baud_pkg.sv | 25 ++
 rtl/baud_frac_divider.sv | 53 +++++
 rtl/baud_tick_generator.sv | 105 ++++++++++
 3 files changed

// File: rtl/baud_pkg.sv
// Shared constants and divisor helpers for the UART baud tick generator.
package baud_pkg;

  localparam int DEFAULT_DIV_INT  = 16;
  localparam int DEFAULT_DIV_FRAC = 0;

  typedef struct packed {
    logic [31:0] divInt;
    logic [31:0] divFrac;
  } divisor_t;

  // Rounds clockHz / (baud * oversample) to the nearest 1/2^fracW clock.
  function automatic divisor_t calcDivisor(input longint clockHz, input longint baud,
                                           input int oversample, input int fracW);
    longint ticksPerSec;
    longint scaled;
    divisor_t d;
    ticksPerSec = baud * longint'(oversample);
    scaled      = ((clockHz << fracW) + ticksPerSec / 2) / ticksPerSec;
    d.divInt    = 32'(scaled >> fracW);
    d.divFrac   = 32'(scaled & ((longint'(1) << fracW) - 1));
    return d;
  endfunction

endpackage

// File: rtl/baud_frac_divider.sv
// Fractional clock divider: counts Aint or Aint+1 cycles per tick, stretching
// a period by one cycle whenever the fractional accumulator carries.
module baud_frac_divider #(
  parameter int INT_W  = 16,
  parameter int FRAC_W = 4
) (
  input  logic              clock,
  input  logic              Reset,
  input  logic              clear,
  input  logic              stall,
  input  logic [INT_W-1:0]  divInt,
  input  logic [FRAC_W-1:0] divFrac,
  output logic              tickNow,
  output logic              osTick
);

  logic [INT_W-1:0]  cnt;
  logic [FRAC_W-1:0] acc;
  logic              extend;
  logic [INT_W:0]    period;
  logic [FRAC_W:0]   accSum;

  // One bit wider than cnt so Aint=2^INT_W-1 plus extend still compares correctly.
  assign period  = {1'b0, divInt} + (INT_W+1)'(extend);
  assign accSum  = {1'b0, acc} + {1'b0, divFrac};
  assign tickNow = !clear && !stall && (({1'b0, cnt} + (INT_W+1)'(1)) == period);

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      cnt    <= '0;
      acc    <= '0;
      extend <= 1'b0;
      osTick <= 1'b0;
    end else if (clear) begin
      cnt    <= '0;
      acc    <= '0;
      extend <= 1'b0;
      osTick <= 1'b0;
    end else if (stall) begin
      cnt    <= '0;
      osTick <= 1'b0;
    end else if (tickNow) begin
      cnt    <= '0;
      osTick <= 1'b1;
      acc    <= accSum[FRAC_W-1:0];
      extend <= accSum[FRAC_W];
    end else begin
      cnt    <= cnt + INT_W'(1);
      osTick <= 1'b0;
    end
  end

endmodule

// File: rtl/baud_tick_generator.sv
// Oversample, mid-bit and bit-boundary strobes for the UART TX/RX paths,
// with a runtime-loadable fractional divisor and start-edge resync.
module baud_tick_generator
  import baud_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int INT_W      = 16,
  parameter int FRAC_W     = 4,
  parameter int PH_W       = $clog2(OVERSAMPLE)
) (
  input  logic              clock,
  input  logic              Reset,
  input  logic              Enable,
  input  logic [INT_W-1:0]  DivInt,
  input  logic [FRAC_W-1:0] DivFrac,
  input  logic              DivLoad,
  input  logic              Resync,
  output logic              OsTick,
  output logic              BitTick,
  output logic              MidTick,
  output logic [PH_W-1:0]   OsPhase,
  output logic              ConfigError
);

  logic [INT_W-1:0]  activeInt;
  logic [INT_W-1:0]  pendingInt;
  logic [INT_W-1:0]  nextInt;
  logic [FRAC_W-1:0] activeFrac;
  logic [FRAC_W-1:0] pendingFrac;
  logic [FRAC_W-1:0] nextFrac;
  logic              pendingValid;
  logic              nextValid;
  logic              applyNow;
  logic              clearCounters;
  logic              tickNow;

  assign ConfigError   = activeInt < INT_W'(2);
  assign clearCounters = !Enable || Resync;

  // A divisor may only take over where no period is in flight: at a tick
  // boundary, on resync, while idle, or while stalled on a bad divisor.
  assign applyNow = !Enable || Resync || ConfigError || tickNow;

  always_comb begin
    nextInt   = pendingInt;
    nextFrac  = pendingFrac;
    nextValid = pendingValid;
    if (DivLoad) begin
      nextInt   = DivInt;
      nextFrac  = DivFrac;
      nextValid = 1'b1;
    end
  end

  baud_frac_divider #(
    .INT_W  (INT_W),
    .FRAC_W (FRAC_W)
  ) u_divider (
    .clock   (clock),
    .Reset   (Reset),
    .clear   (clearCounters),
    .stall   (ConfigError),
    .divInt  (activeInt),
    .divFrac (activeFrac),
    .tickNow (tickNow),
    .osTick  (OsTick)
  );

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      activeInt    <= INT_W'(DEFAULT_DIV_INT);
      activeFrac   <= FRAC_W'(DEFAULT_DIV_FRAC);
      pendingInt   <= '0;
      pendingFrac  <= '0;
      pendingValid <= 1'b0;
      OsPhase      <= '0;
      BitTick      <= 1'b0;
      MidTick      <= 1'b0;
    end else begin
      if (nextValid && applyNow) begin
        activeInt    <= nextInt;
        activeFrac   <= nextFrac;
        pendingValid <= 1'b0;
      end else begin
        pendingInt   <= nextInt;
        pendingFrac  <= nextFrac;
        pendingValid <= nextValid;
      end

      if (clearCounters) begin
        OsPhase <= '0;
        BitTick <= 1'b0;
        MidTick <= 1'b0;
      end else if (tickNow) begin
        OsPhase <= OsPhase + PH_W'(1);
        BitTick <= (OsPhase == PH_W'(OVERSAMPLE - 1));
        MidTick <= (OsPhase == PH_W'(OVERSAMPLE / 2 - 1));
      end else begin
        BitTick <= 1'b0;
        MidTick <= 1'b0;
      end
    end
  end

endmodule
